timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Control and register block for the 64-bit timer counter. It decodes register writes and reads, drives the counter's TDR write selects and `count_en`, and runs a power-of-two prescaler. It also handles a debug-halt handshake and raises a compare-match interrupt. It sits between the system register bus and the counter datapath; the counter's `count` output feeds back in here for compare and readback.

## Interface
- No parameters; all widths fixed.
- `sys_clk` in 1: sole clock, rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: register write strobe, one cycle per write.
- `rd_en` in 1: register read strobe.
- `addr` in 12: byte address; bits [1:0] ignored.
- `wdata` in 32: write data, also forwarded to the counter.
- `rdata` out 32: read data.
- `count` in 64: current counter value.
- `tdr0_wr_sel` out 1: load counter low word from `wdata`.
- `tdr1_wr_sel` out 1: load counter high word from `wdata`.
- `count_en` out 1: counter increment enable.
- `dbg_mode` in 1: system debug mode.
- `tim_int` out 1: interrupt, level.

## Operation
Register map (offset, reset value):
- TCR 0x00, 0x0000_0100: bit0 `timer_en`, bit1 `div_en`, bits[11:8] `div_val`.
- TDR0 0x04 and TDR1 0x08: alias the counter words.
- TCMP0 0x0C and TCMP1 0x10: 0xFFFF_FFFF each.
- TIER 0x14, 0: bit0 `int_en`.
- TISR 0x18, 0: bit0 `int_st`, write-1-to-clear.
- THCSR 0x1C, 0: bit0 `halt_req` (RW), bit1 `halt_ack` (RO).

TCR write rules:
- A write with `div_val` > 8 is discarded entirely; TCR is unchanged.
- While `timer_en`=1 and the write keeps bit0=1, `div_en` and `div_val` keep their old values. Only `timer_en` is writable in that case.

Other register rules:
- Unmapped addresses: writes ignored, reads return 0. Unused bits read 0.
- `tdr0_wr_sel` = `wr_en` & addr==0x04; `tdr1_wr_sel` = `wr_en` & addr==0x08. Both are combinational.
- `rdata` is combinational; it is 0 when `rd_en`=0. TDR0/1 reads return `count[31:0]`/`count[63:32]`.

Halt and prescaler:
- `halted` = `dbg_mode` & `halt_req`. `halt_ack` reads `halted`.
- Prescaler counter `int_cnt` (8 bits) has limit = 2^`div_val` − 1.
- `int_cnt` clears when `timer_en`=0, `div_en`=0, or TCR is written; it also wraps to 0 at limit.
- `int_cnt` increments only when `timer_en`=1, `div_en`=1 and not `halted`. While halted it holds its value.
- `count_en` = `timer_en` & ~`halted` & (~`div_en` | `int_cnt`==limit).

Interrupt:
- `int_st` sets when `count` == {TCMP1,TCMP0} and stays set until cleared. It sets whatever the value of `int_en`.
- A TISR write with bit0=1 clears `int_st`. If a match occurs in the same cycle, the set wins.
- `tim_int` = `int_st` & `int_en`.

## Timing
- After reset: all outputs are 0 (`rdata`, `count_en`, both wr_sel, `tim_int`), and all registers hold their listed reset values.
- Register writes take effect at the clock edge where `wr_en` is high. `count_en` reflects the new TCR from the next cycle.
- The counter increments at the edge where `count_en` is high. With `div_en`=1 it increments once every 2^`div_val` cycles (`div_val`=0 means every cycle).
- `int_st` rises one edge after `count` equals the compare value; `tim_int` follows combinationally.
- `halt_ack` rises combinationally once `dbg_mode` and `halt_req` are both high. `count_en` is 0 in the same cycle.
- Counter-word writes override `count_en` in the datapath. This block does not gate `count_en` during those writes.
- Reset asserted mid-operation returns the block to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `timer_pkg`:
  - register offsets;
  - TCR field positions;
  - reset constants: TCR 0x100, TCMP 0xFFFF_FFFF;
  - `DIV_MAX` = 8.
- One sub-module, `timer_prescaler`:
  - inputs: `timer_en`, `div_en`, `div_val`, `halted`, clear pulse;
  - output: `count_en`.
- Register file, halt logic and interrupt logic stay in `timer_ctrl`.

## Test plan
- Reset, then read all registers. Required: TCR=0x100, TCMP0=TCMP1=0xFFFF_FFFF, all others 0; `tim_int`=0.
- Write TCR=0x0000_0203 (div_en, `div_val`=2, enable). Required: `count_en` pulses every 4th cycle, and `count` reaches 5 after 20 cycles.
- Write TCR with `div_val`=9. Required: TCR unchanged. With the timer running, write TCR=0x0000_0501. Required: TCR reads 0x0000_0203 (`div_en`, `div_val` unchanged).
- Load TDR0=0xFFFF_FFFE and TDR1=0. Set TCMP0=0, TCMP1=1, `int_en`=1, then enable with no divider. Required: the word carries into TDR1 after 2 cycles, `int_st` sets one cycle after the match, and `tim_int`=1.
- Write TISR=1 in the same cycle as a new match. Required: `int_st` stays 1. Write TISR=1 with no match. Required: `int_st` and `tim_int` go to 0.
- Set `dbg_mode`=1 and `halt_req`=1 mid-count. Required: `halt_ack`=1, `count` frozen for 10 cycles, `int_cnt` held. After release, counting resumes with no lost or extra pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer control block.
package timer_pkg;

  // Register byte offsets
  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] TCMP0_OFF = 12'h00C;
  localparam logic [11:0] TCMP1_OFF = 12'h010;
  localparam logic [11:0] TIER_OFF  = 12'h014;
  localparam logic [11:0] TISR_OFF  = 12'h018;
  localparam logic [11:0] THCSR_OFF = 12'h01C;

  // Word indices (byte address bits [11:2])
  localparam logic [9:0] TCR_W   = TCR_OFF[11:2];
  localparam logic [9:0] TDR0_W  = TDR0_OFF[11:2];
  localparam logic [9:0] TDR1_W  = TDR1_OFF[11:2];
  localparam logic [9:0] TCMP0_W = TCMP0_OFF[11:2];
  localparam logic [9:0] TCMP1_W = TCMP1_OFF[11:2];
  localparam logic [9:0] TIER_W  = TIER_OFF[11:2];
  localparam logic [9:0] TISR_W  = TISR_OFF[11:2];
  localparam logic [9:0] THCSR_W = THCSR_OFF[11:2];

  // TCR field positions
  localparam int unsigned TCR_EN_BIT     = 0;
  localparam int unsigned TCR_DIV_EN_BIT = 1;
  localparam int unsigned TCR_DIV_LSB    = 8;
  localparam int unsigned TCR_DIV_W      = 4;

  // Reset constants
  localparam logic [31:0] TCR_RST  = 32'h0000_0100;
  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Largest accepted prescaler exponent
  localparam logic [TCR_DIV_W-1:0] DIV_MAX = 4'd8;

  typedef struct packed {
    logic                 timer_en;
    logic                 div_en;
    logic [TCR_DIV_W-1:0] div_val;
  } tcr_t;

  localparam tcr_t TCR_RST_FIELDS = '{
    timer_en: TCR_RST[TCR_EN_BIT],
    div_en:   TCR_RST[TCR_DIV_EN_BIT],
    div_val:  TCR_RST[TCR_DIV_LSB +: TCR_DIV_W]
  };

  // Place TCR fields at their bus positions
  function automatic logic [31:0] tcr_pack(tcr_t t);
    logic [31:0] w;
    w = '0;
    w[TCR_EN_BIT]                 = t.timer_en;
    w[TCR_DIV_EN_BIT]             = t.div_en;
    w[TCR_DIV_LSB +: TCR_DIV_W]   = t.div_val;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler producing the counter increment enable.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 timer_en,
  input  logic                 div_en,
  input  logic [TCR_DIV_W-1:0] div_val,
  input  logic                 halted,
  input  logic                 clr,
  output logic                 count_en
);

  logic [7:0] int_cnt_q, int_cnt_d;
  logic [7:0] limit;
  logic       at_limit;

  // Limit 2^div_val - 1; div_val never exceeds 8 so it fits in 8 bits
  always_comb begin
    limit    = 8'((9'd1 << div_val) - 9'd1);
    at_limit = (int_cnt_q == limit);
    count_en = timer_en & ~halted & (~div_en | at_limit);
  end

  // Next prescaler count: clear, hold while halted, wrap at limit
  always_comb begin
    int_cnt_d = int_cnt_q;
    if (clr || !timer_en || !div_en) begin
      int_cnt_d = '0;
    end else if (!halted) begin
      int_cnt_d = at_limit ? '0 : int_cnt_q + 8'd1;
    end
  end

  // Prescaler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_cnt_q <= '0;
    else        int_cnt_q <= int_cnt_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Register block, halt handshake and compare interrupt for the 64-bit timer.
module timer_ctrl
  import timer_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [63:0] count,
  output logic        tdr0_wr_sel,
  output logic        tdr1_wr_sel,
  output logic        count_en,
  input  logic        dbg_mode,
  output logic        tim_int
);

  tcr_t        tcr_q, tcr_d;
  logic [31:0] tcmp0_q, tcmp0_d;
  logic [31:0] tcmp1_q, tcmp1_d;
  logic        int_en_q, int_en_d;
  logic        int_st_q, int_st_d;
  logic        halt_req_q, halt_req_d;

  logic [9:0]  word;
  logic        halted;
  logic        cmp_match;
  logic        tcr_wr;
  logic [1:0]  unused_addr_lsb;

  always_comb unused_addr_lsb = addr[1:0];

  // Decode, halt and compare; counter-word selects pass straight through
  always_comb begin
    word        = addr[11:2];
    halted      = dbg_mode & halt_req_q;
    cmp_match   = (count == {tcmp1_q, tcmp0_q});
    tdr0_wr_sel = wr_en & (word == TDR0_W);
    tdr1_wr_sel = wr_en & (word == TDR1_W);
    tim_int     = int_st_q & int_en_q;
  end

  // Register next-state: writes, TCR lock rules, W1C with set priority
  always_comb begin
    tcr_d      = tcr_q;
    tcmp0_d    = tcmp0_q;
    tcmp1_d    = tcmp1_q;
    int_en_d   = int_en_q;
    int_st_d   = int_st_q;
    halt_req_d = halt_req_q;
    tcr_wr     = 1'b0;
    if (wr_en) begin
      case (word)
        TCR_W: begin
          if (wdata[TCR_DIV_LSB +: TCR_DIV_W] <= DIV_MAX) begin
            tcr_wr = 1'b1;
            // A running timer that stays enabled keeps its divider setting
            if (!(tcr_q.timer_en && wdata[TCR_EN_BIT])) begin
              tcr_d.timer_en = wdata[TCR_EN_BIT];
              tcr_d.div_en   = wdata[TCR_DIV_EN_BIT];
              tcr_d.div_val  = wdata[TCR_DIV_LSB +: TCR_DIV_W];
            end
          end
        end
        TCMP0_W: tcmp0_d    = wdata;
        TCMP1_W: tcmp1_d    = wdata;
        TIER_W:  int_en_d   = wdata[0];
        TISR_W:  if (wdata[0]) int_st_d = 1'b0;
        THCSR_W: halt_req_d = wdata[0];
        default: ;
      endcase
    end
    if (cmp_match) int_st_d = 1'b1;
  end

  // Register file state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tcr_q      <= TCR_RST_FIELDS;
      tcmp0_q    <= TCMP_RST;
      tcmp1_q    <= TCMP_RST;
      int_en_q   <= 1'b0;
      int_st_q   <= 1'b0;
      halt_req_q <= 1'b0;
    end else begin
      tcr_q      <= tcr_d;
      tcmp0_q    <= tcmp0_d;
      tcmp1_q    <= tcmp1_d;
      int_en_q   <= int_en_d;
      int_st_q   <= int_st_d;
      halt_req_q <= halt_req_d;
    end
  end

  // Read mux; unmapped words and idle strobe return zero
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (word)
        TCR_W:   rdata = tcr_pack(tcr_q);
        TDR0_W:  rdata = count[31:0];
        TDR1_W:  rdata = count[63:32];
        TCMP0_W: rdata = tcmp0_q;
        TCMP1_W: rdata = tcmp1_q;
        TIER_W:  rdata = {31'd0, int_en_q};
        TISR_W:  rdata = {31'd0, int_st_q};
        THCSR_W: rdata = {30'd0, halted, halt_req_q};
        default: rdata = '0;
      endcase
    end
  end

  timer_prescaler u_prescaler (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .timer_en (tcr_q.timer_en),
    .div_en   (tcr_q.div_en),
    .div_val  (tcr_q.div_val),
    .halted   (halted),
    .clr      (tcr_wr),
    .count_en (count_en)
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: reference model plus directed register sequences.
module tb_timer_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wr_en, rd_en;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [63:0] tb_count;
  logic        tdr0_wr_sel, tdr1_wr_sel, count_en;
  logic        dbg_mode;
  logic        tim_int;

  int total = 0;
  int bad   = 0;

  // Reference model state (value after the most recent clock edge)
  logic [31:0] m_tcr, m_cmp0, m_cmp1;
  logic        m_ie, m_is, m_hreq;
  int unsigned m_n;  // enabled, non-halted cycles since prescaler clear, mod period

  logic [63:0] snap;

  always #5 sys_clk = ~sys_clk;

  timer_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .count       (tb_count),
    .tdr0_wr_sel (tdr0_wr_sel),
    .tdr1_wr_sel (tdr1_wr_sel),
    .count_en    (count_en),
    .dbg_mode    (dbg_mode),
    .tim_int     (tim_int)
  );

  // Counter datapath stand-in: word loads override increment
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       tb_count <= 64'd0;
    else if (tdr0_wr_sel) tb_count[31:0]  <= wdata;
    else if (tdr1_wr_sel) tb_count[63:32] <= wdata;
    else if (count_en)    tb_count <= tb_count + 64'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tcr  = 32'h0000_0100;
    m_cmp0 = 32'hFFFF_FFFF;
    m_cmp1 = 32'hFFFF_FFFF;
    m_ie   = 1'b0;
    m_is   = 1'b0;
    m_hreq = 1'b0;
    m_n    = 0;
  endtask

  task automatic compare_outputs();
    logic [31:0] er;
    logic        halted, ecen;
    int unsigned per;
    halted = dbg_mode & m_hreq;
    per    = 32'd1 << m_tcr[11:8];
    er     = 32'd0;
    if (rd_en) begin
      case (addr[11:2])
        10'd0:   er = m_tcr;
        10'd1:   er = tb_count[31:0];
        10'd2:   er = tb_count[63:32];
        10'd3:   er = m_cmp0;
        10'd4:   er = m_cmp1;
        10'd5:   er = {31'd0, m_ie};
        10'd6:   er = {31'd0, m_is};
        10'd7:   er = {30'd0, halted, m_hreq};
        default: er = 32'd0;
      endcase
    end
    ecen = m_tcr[0] & ~halted & (~m_tcr[1] | (m_n == per - 1));
    chk("rdata",       64'(rdata),       64'(er));
    chk("tdr0_wr_sel", 64'(tdr0_wr_sel), 64'(wr_en && addr[11:2] == 10'd1));
    chk("tdr1_wr_sel", 64'(tdr1_wr_sel), 64'(wr_en && addr[11:2] == 10'd2));
    chk("count_en",    64'(count_en),    64'(ecen));
    chk("tim_int",     64'(tim_int),     64'(m_is & m_ie));
  endtask

  task automatic model_advance();
    logic        halted, match, tcr_acc;
    int unsigned per;
    halted  = dbg_mode & m_hreq;
    per     = 32'd1 << m_tcr[11:8];
    match   = (tb_count == {m_cmp1, m_cmp0});
    tcr_acc = wr_en && addr[11:2] == 10'd0 && wdata[11:8] <= 4'd8;
    if (tcr_acc || !m_tcr[0] || !m_tcr[1]) m_n = 0;
    else if (!halted)                      m_n = (m_n + 1) % per;
    if (match)                                         m_is = 1'b1;
    else if (wr_en && addr[11:2] == 10'd6 && wdata[0]) m_is = 1'b0;
    if (wr_en) begin
      case (addr[11:2])
        10'd0: if (tcr_acc && !(m_tcr[0] && wdata[0])) m_tcr = wdata & 32'h0000_0F03;
        10'd3: m_cmp0 = wdata;
        10'd4: m_cmp1 = wdata;
        10'd5: m_ie   = wdata[0];
        10'd7: m_hreq = wdata[0];
        default: ;
      endcase
    end
  endtask

  // One clock: check at the falling edge, advance model, return just after rising edge
  task automatic step();
    @(negedge sys_clk);
    if (!sys_rst_n) model_reset();
    compare_outputs();
    if (sys_rst_n) model_advance();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    step();
    wr_en = 1'b0; addr = 12'h0; wdata = 32'h0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    rd_en = 1'b1; addr = a;
    #2;
    chk(name, 64'(rdata), 64'(exp));
    step();
    rd_en = 1'b0; addr = 12'h0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = 12'h0; wdata = 32'h0; dbg_mode = 1'b0;
    model_reset();
    steps(2);
    sys_rst_n = 1'b1;

    // Reset values
    chk("rst_tim_int", 64'(tim_int), 64'd0);
    chk("rst_count_en", 64'(count_en), 64'd0);
    rd(12'h000, 32'h0000_0100, "rst_tcr");
    rd(12'h004, 32'h0000_0000, "rst_tdr0");
    rd(12'h008, 32'h0000_0000, "rst_tdr1");
    rd(12'h00C, 32'hFFFF_FFFF, "rst_tcmp0");
    rd(12'h010, 32'hFFFF_FFFF, "rst_tcmp1");
    rd(12'h014, 32'h0000_0000, "rst_tier");
    rd(12'h018, 32'h0000_0000, "rst_tisr");
    rd(12'h01C, 32'h0000_0000, "rst_thcsr");
    rd(12'h020, 32'h0000_0000, "unmapped_rd");
    rd(12'h013, 32'hFFFF_FFFF, "tcmp1_addr_lsb_ignored");
    wr(12'h020, 32'hFFFF_FFFF);
    rd(12'h000, 32'h0000_0100, "unmapped_wr_no_effect");

    // Divide by 4: five increments in twenty cycles
    wr(12'h000, 32'h0000_0203);
    steps(20);
    chk("div4_count_20cyc", tb_count, 64'd5);

    // Over-range divider discarded; locked divider while running
    wr(12'h000, 32'h0000_0903);
    rd(12'h000, 32'h0000_0203, "tcr_div9_discard");
    wr(12'h000, 32'h0000_0501);
    rd(12'h000, 32'h0000_0203, "tcr_locked_fields");
    steps(3);

    // Debug halt mid-count
    dbg_mode = 1'b1;
    steps(2);
    wr(12'h01C, 32'h0000_0001);
    rd(12'h01C, 32'h0000_0003, "halt_ack");
    chk("halt_count_en", 64'(count_en), 64'd0);
    snap = tb_count;
    steps(10);
    chk("halt_count_frozen", tb_count, snap);
    wr(12'h01C, 32'h0000_0000);
    steps(12);
    dbg_mode = 1'b0;
    steps(2);

    // Carry into high word and compare match
    wr(12'h000, 32'h0000_0000);
    wr(12'h004, 32'hFFFF_FFFE);
    wr(12'h008, 32'h0000_0000);
    wr(12'h00C, 32'h0000_0000);
    wr(12'h010, 32'h0000_0001);
    wr(12'h014, 32'h0000_0001);
    wr(12'h000, 32'h0000_0001);
    steps(2);
    chk("carry_count", tb_count, 64'h0000_0001_0000_0000);
    chk("tim_int_not_yet", 64'(tim_int), 64'd0);
    step();
    chk("tim_int_after_match", 64'(tim_int), 64'd1);
    rd(12'h018, 32'h0000_0001, "tisr_set");

    // W1C coinciding with a match: set wins
    wr(12'h000, 32'h0000_0000);
    wr(12'h004, 32'h0000_0000);
    wr(12'h008, 32'h0000_0001);
    wr(12'h018, 32'h0000_0001);
    rd(12'h018, 32'h0000_0001, "tisr_set_wins");
    wr(12'h00C, 32'h0000_0005);
    wr(12'h018, 32'h0000_0001);
    rd(12'h018, 32'h0000_0000, "tisr_cleared");
    chk("tim_int_cleared", 64'(tim_int), 64'd0);

    // Run to next match, then asynchronous reset mid-cycle
    wr(12'h000, 32'h0000_0001);
    steps(6);
    chk("tim_int_second_match", 64'(tim_int), 64'd1);
    chk("count_en_running", 64'(count_en), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_count_en", 64'(count_en), 64'd0);
    chk("async_rst_tim_int", 64'(tim_int), 64'd0);
    steps(2);
    sys_rst_n = 1'b1;
    rd(12'h000, 32'h0000_0100, "post_rst_tcr");
    rd(12'h00C, 32'hFFFF_FFFF, "post_rst_tcmp0");
    rd(12'h014, 32'h0000_0000, "post_rst_tier");
    steps(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
